fp_div_sequencer: RTL and testbench

FP_DIV_SEQUENCER -- requirements
Module: fp_div_sequencer

---
 rtl/fp_div_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sequencer.sv
// FP divide sequencer: operand FIFO, special-case bypass, divider handshake.
// Define FP_DIV_SEQ_TIMEOUT_EN to enable the divider wait watchdog.
module fp_div_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic [31:0]      div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 64 + TAG_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_ISSUE,
    S_WAIT_BUSY, S_WAIT_DONE, S_OUTPUT
  } state_t;

  state_t r_state, w_next;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full, w_empty, w_push, w_pop;

  logic [31:0]      r_a, r_b, r_result;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_flags;

  logic             w_special, w_inv, w_dz, w_sign;
  logic [31:0]      w_byp;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf;
  logic             w_done_fire, w_to, w_to_fire;

  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_tag, in_b, in_a};
  end

  // Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_zero = (r_a[30:0] == '0);
  assign w_b_zero = (r_b[30:0] == '0);
  assign w_a_inf  = (r_a[30:23] == 8'hFF);
  assign w_b_inf  = (r_b[30:23] == 8'hFF);

  always_comb begin
    w_special = 1'b1;
    w_inv     = 1'b0;
    w_dz      = 1'b0;
    w_byp     = '0;
    if (w_a_zero && w_b_zero) begin
      w_byp = 32'h7FC00000;
      w_inv = 1'b1;
    end else if (w_b_zero) begin
      w_byp = {w_sign, 8'hFF, 23'h0};
      w_dz  = 1'b1;
    end else if (w_a_inf) begin
      w_byp = {w_sign, 8'hFF, 23'h0};
    end else if (w_b_inf || w_a_zero) begin
      w_byp = {w_sign, 31'h0};
    end else begin
      w_special = 1'b0;
    end
  end

`ifdef FP_DIV_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_wait;

  assign w_wait = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_to   = w_wait && (r_to_cnt >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_wait) r_to_cnt <= '0;
    else                r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_to = 1'b0;
`endif

  assign w_done_fire = (r_state == S_WAIT_DONE) && !div_busy && div_valid;
  assign w_to_fire   = w_to && !w_done_fire;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (!w_empty) w_next = S_CLASSIFY;
      S_CLASSIFY:  w_next = w_special ? S_OUTPUT : S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_to)          w_next = S_OUTPUT;
        else if (div_busy) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (w_done_fire || w_to) w_next = S_OUTPUT;
      S_OUTPUT:    if (out_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    div_start = (r_state == S_ISSUE);
    out_valid = (r_state == S_OUTPUT);
    w_pop     = (r_state == S_IDLE) && !w_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_pop) {r_tag, r_b, r_a} <= r_mem[r_rd_ptr];
      if (r_state == S_CLASSIFY && w_special) begin
        r_result <= w_byp;
        r_flags  <= {1'b0, w_inv, w_dz, 1'b1};
      end else if (w_done_fire) begin
        r_result <= div_result;
        r_flags  <= 4'b0000;
      end else if (w_to_fire) begin
        r_result <= 32'h7FC00000;
        r_flags  <= 4'b1000;
      end
    end
  end

  assign div_dividend = r_a;
  assign div_divisor  = r_b;
  assign out_result   = r_result;
  assign out_tag      = r_tag;
  assign out_flags    = r_flags;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer with a small behavioural divider.
// Define FP_DIV_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_fp_div_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_start;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_busy = 1'b0;
  logic             div_valid = 1'b0;
  logic [31:0]      div_result = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  int ncmp = 0;
  int nfail = 0;
  int n_start = 0;
  int s0, lat, g, nout;
  logic dv_en = 1'b1;
  logic dv_pend = 1'b0;
  logic [2:0] dv_cnt = '0;
  logic [31:0] qa [4];

  always #5 clk = ~clk;

  fp_div_sequencer #(.FIFO_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_busy(div_busy), .div_valid(div_valid),
    .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_flags(out_flags)
  );

  // Divider: busy rises one cycle after start, so the prior valid is stale.
  always @(posedge clk) begin
    if (rst) begin
      div_busy  <= 1'b0;
      div_valid <= 1'b0;
      dv_pend   <= 1'b0;
      dv_cnt    <= '0;
    end else if (div_start && dv_en) begin
      dv_pend <= 1'b1;
    end else if (dv_pend) begin
      dv_pend   <= 1'b0;
      div_busy  <= 1'b1;
      div_valid <= 1'b0;
      dv_cnt    <= 3'd2;
    end else if (div_busy) begin
      if (dv_cnt == 0) begin
        div_busy   <= 1'b0;
        div_valid  <= 1'b1;
        div_result <= (div_divisor == 32'h3F800000) ?
                      div_dividend : 32'hDEADBEEF;
      end else begin
        dv_cnt <= dv_cnt - 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && div_start) n_start <= n_start + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int maxc);
    int k;
    k = 0;
    while (!out_valid && k < maxc) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic step;
    logic acc;
    acc = in_valid && in_ready;
    tick();
    if (acc) in_valid = 1'b0;
  endtask

  task automatic byp(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic [TAG_W-1:0] t,
                     input logic [31:0] er, input logic [3:0] ef);
    int s;
    s = n_start;
    push(a, b, t);
    wait_out(tag, 20);
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_flags"}, 32'(out_flags), 32'(ef));
    chk({tag, "_tag"}, 32'(out_tag), 32'(t));
    chk({tag, "_nostart"}, n_start - s, 0);
    drain();
  endtask

  initial begin
    qa[0] = 32'h40000000;
    qa[1] = 32'h40400000;
    qa[2] = 32'h40800000;
    qa[3] = 32'h40A00000;

    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", 32'(out_tag), 0);
    chk("rst_flags", 32'(out_flags), 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);

    s0 = n_start;
    push(32'h40400000, 32'h3F800000, 4'd5);
    wait_out("div3", 50);
    chk("div3_res", out_result, 32'h40400000);
    chk("div3_tag", 32'(out_tag), 5);
    chk("div3_flags", 32'(out_flags), 0);
    chk("div3_starts", n_start - s0, 1);
    chk("div3_dividend", div_dividend, 32'h40400000);
    chk("div3_divisor", div_divisor, 32'h3F800000);
    tick();
    tick();
    chk("hold_valid", 32'(out_valid), 1);
    chk("hold_res", out_result, 32'h40400000);
    chk("hold_tag", 32'(out_tag), 5);
    drain();
    chk("drain_valid", 32'(out_valid), 0);

    s0 = n_start;
    in_valid = 1'b1;
    in_a = 32'h3F800000;
    in_b = 32'h00000000;
    in_tag = 4'd3;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("dz_latency", lat, 3);
    chk("dz_res", out_result, 32'h7F800000);
    chk("dz_flags", 32'(out_flags), 32'h3);
    chk("dz_nostart", n_start - s0, 0);
    drain();

    byp("zz", 32'h00000000, 32'h00000000, 4'd1, 32'h7FC00000, 4'b0101);
    byp("nzz", 32'h80000000, 32'h00000000, 4'd2, 32'h7FC00000, 4'b0101);
    byp("m1inf", 32'hBF800000, 32'h7F800000, 4'd4, 32'h80000000, 4'b0001);
    byp("ninf", 32'hFF800000, 32'h3F800000, 4'd6, 32'hFF800000, 4'b0001);
    byp("infinf", 32'h7F800000, 32'h7F800000, 4'd7, 32'h7F800000, 4'b0001);
    byp("zneg", 32'h00000000, 32'hC0000000, 4'd8, 32'h80000000, 4'b0001);
    byp("nanz", 32'h7FC00000, 32'h00000000, 4'd9, 32'h7F800000, 4'b0011);

    push(32'h00000000, 32'h3F800000, 4'd0);
    wait_out("q_head", 20);
    s0 = n_start;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q_ready%0d", i), 32'(in_ready), 1);
      in_valid = 1'b1;
      in_a = qa[i];
      in_b = 32'h3F800000;
      in_tag = 4'(i + 1);
      tick();
    end
    in_a = 32'h40C00000;
    in_tag = 4'd5;
    chk("q_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = 0;
      while (!out_valid && g < 60) begin
        step();
        g++;
      end
      chk($sformatf("q%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("q%0d_tag", k), 32'(out_tag), 32'(k));
      chk($sformatf("q%0d_res", k), out_result,
          (k == 0) ? 32'h0 : (k == 5) ? 32'h40C00000 : qa[k-1]);
      step();
    end
    out_ready = 1'b0;
    chk("q_starts", n_start - s0, 5);

    push(32'h00000000, 32'h3F800000, 4'd3);
    wait_out("rstout", 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstout_valid", 32'(out_valid), 0);
    chk("rstout_flags", 32'(out_flags), 0);

    push(32'h40800000, 32'h3F800000, 4'd7);
    push(32'h40400000, 32'h3F800000, 4'd8);
    push(32'h40000000, 32'h3F800000, 4'd9);
    g = 0;
    while (!div_busy && g < 20) begin
      tick();
      g++;
    end
    chk("mid_busy", 32'(div_busy), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_dividend", div_dividend, 0);
    s0 = n_start;
    nout = 0;
    out_ready = 1'b1;
    repeat (40) begin
      tick();
      if (out_valid) nout++;
    end
    out_ready = 1'b0;
    chk("mid_no_output", nout, 0);
    chk("mid_no_start", n_start - s0, 0);

`ifdef FP_DIV_SEQ_TIMEOUT_EN
    dv_en = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h40400000;
    in_b = 32'h3F800000;
    in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("to_latency", lat, 67);
    chk("to_res", out_result, 32'h7FC00000);
    chk("to_flags", 32'(out_flags), 32'h8);
    chk("to_tag", 32'(out_tag), 9);
    drain();
    dv_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
